// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
// Contents:
//   state_e          FSM states (IDLE, EXEC, RESP)
//   CMD_*            ALU command encodings driven on EXE_CMD
//   ID_A / ID_B      requester ids (bit index into the 2-bit channels)
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] CMD_ADD = 4'd0;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_AND = 4'd4;
  localparam logic [3:0] CMD_OR  = 4'd5;
  localparam logic [3:0] CMD_NOR = 4'd6;
  localparam logic [3:0] CMD_XOR = 4'd7;
  localparam logic [3:0] CMD_SHL = 4'd8;
  localparam logic [3:0] CMD_SAR = 4'd9;
  localparam logic [3:0] CMD_SHR = 4'd10;
  localparam logic [3:0] CMD_NOP = 4'd15;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

endpackage

// File: rtl/alu_arbiter_rr_grant2.sv
// rr_grant2: two-input round-robin grant.
// Ports:
//   valid_i  [1:0]  request valids (bit 0 = A, bit 1 = B)
//   rr_i            preferred requester when both are valid (0=A, 1=B)
//   grant_o  [1:0]  one-hot grant, or 0 when nothing is valid
//   win_o           id of the granted requester (meaningful only if grant_o != 0)
module rr_grant2
  import alu_arbiter_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       rr_i,
  output logic [1:0] grant_o,
  output logic       win_o
);

  always_comb begin
    // A lone requester wins regardless of the pointer.
    grant_o = valid_i;
    if (&valid_i) grant_o = rr_i ? 2'b10 : 2'b01;
    win_o = grant_o[1] ? ID_B : ID_A;
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// One operation in flight: IDLE (grant) -> EXEC (drive ALU, capture) -> RESP.
// Ports:
//   clk, rst                      clock, async active-low reset
//   req_valid/req_ready [1:0]     request channel per requester (0=A, 1=B)
//   val1_*/val2_*/EXE_CMD_*       request payload per requester
//   resp_valid/resp_ready [1:0]   response channel per requester
//   resp_data                     shared result, 0 when no response is valid
//   alu_val1/alu_val2/alu_EXE_CMD operands to the ALU (0/0/NOP outside EXEC)
//   alu_out                       ALU result
//   busy                          high whenever not IDLE
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CMD_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] val1_a,
  input  logic [WIDTH-1:0] val2_a,
  input  logic [WIDTH-1:0] val1_b,
  input  logic [WIDTH-1:0] val2_b,
  input  logic [CMD_W-1:0] EXE_CMD_a,
  input  logic [CMD_W-1:0] EXE_CMD_b,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic [WIDTH-1:0] alu_val1,
  output logic [WIDTH-1:0] alu_val2,
  output logic [CMD_W-1:0] alu_EXE_CMD,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy
);

  localparam logic [CMD_W-1:0] NOP = CMD_W'(CMD_NOP);

  state_e           state_q, state_d;
  logic             rr_q, owner_q;
  logic [WIDTH-1:0] v1_q, v2_q, res_q;
  logic [CMD_W-1:0] cmd_q;
  logic [1:0]       grant;
  logic             win;
  logic             req_hs, resp_hs;

  rr_grant2 u_grant (
    .valid_i (req_valid),
    .rr_i    (rr_q),
    .grant_o (grant),
    .win_o   (win)
  );

  assign req_hs  = |(req_valid & req_ready);
  // Only the owner's ready can close the response.
  assign resp_hs = (state_q == ST_RESP) && resp_ready[owner_q];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_hs)  state_d = ST_EXEC;
      ST_EXEC:              state_d = ST_RESP;
      ST_RESP: if (resp_hs) state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready   = 2'b00;
    resp_valid  = 2'b00;
    resp_data   = '0;
    alu_val1    = '0;
    alu_val2    = '0;
    alu_EXE_CMD = NOP;
    busy        = (state_q != ST_IDLE);
    case (state_q)
      // Gating with rst keeps ready low for the whole reset window.
      ST_IDLE: if (rst) req_ready = grant;
      ST_EXEC: begin
        alu_val1    = v1_q;
        alu_val2    = v2_q;
        alu_EXE_CMD = cmd_q;
      end
      ST_RESP: begin
        resp_valid[owner_q] = 1'b1;
        resp_data           = res_q;
      end
      default: ;
    endcase
  end

  // Datapath: latched request, owner, round-robin pointer, result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q    <= ID_A;
      owner_q <= ID_A;
      v1_q    <= '0;
      v2_q    <= '0;
      cmd_q   <= '0;
      res_q   <= '0;
    end else begin
      if (req_hs) begin
        owner_q <= win;
        rr_q    <= ~win;
        v1_q    <= win ? val1_b : val1_a;
        v2_q    <= win ? val2_b : val2_a;
        cmd_q   <= win ? EXE_CMD_b : EXE_CMD_a;
      end
      if (state_q == ST_EXEC) res_q <= alu_out;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [31:0] val1_a, val2_a, val1_b, val2_b;
  logic [3:0]  EXE_CMD_a, EXE_CMD_b, alu_EXE_CMD;
  logic [31:0] resp_data, alu_val1, alu_val2, alu_out;
  logic        busy;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .CMD_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .val1_a(val1_a), .val2_a(val2_a), .val1_b(val1_b), .val2_b(val2_b),
    .EXE_CMD_a(EXE_CMD_a), .EXE_CMD_b(EXE_CMD_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_EXE_CMD(alu_EXE_CMD),
    .alu_out(alu_out), .busy(busy)
  );

  // The shared ALU lives in the environment.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] c);
    logic [31:0] r;
    case (c)
      4'd0:    r = a + b;
      4'd2:    r = a - b;
      4'd4:    r = a & b;
      4'd5:    r = a | b;
      4'd6:    r = ~(a | b);
      4'd7:    r = a ^ b;
      4'd8:    r = a << b[4:0];
      4'd9:    r = $signed(a) >>> b[4:0];
      4'd10:   r = a >> b[4:0];
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign alu_out = alu_f(alu_val1, alu_val2, alu_EXE_CMD);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  // The model knows only: who is owed service, how many cycles an accepted
  // operation has been in flight, and what result it owes.
  logic        m_inflight = 1'b0;
  int          m_age = 0;
  logic        m_own = 1'b0;
  logic        m_rr = 1'b0;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_c;
  logic [1:0]  e_rdy, e_rv;

  function automatic logic [1:0] pick(input logic [1:0] v, input logic rr);
    if (v == 2'b11) return rr ? 2'b10 : 2'b01;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst req_ready", req_ready, 2'b00);
      chk("rst resp_valid", resp_valid, 2'b00);
      chk("rst resp_data", resp_data, 0);
      chk("rst busy", busy, 0);
      chk("rst alu_cmd", alu_EXE_CMD, 4'd15);
      chk("rst alu_v1", alu_val1, 0);
      chk("rst alu_v2", alu_val2, 0);
      m_inflight = 1'b0;
      m_rr       = 1'b0;
    end else begin
      e_rdy = m_inflight ? 2'b00 : pick(req_valid, m_rr);
      e_rv  = (m_inflight && m_age >= 1) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
      chk("req_ready", req_ready, e_rdy);
      chk("busy", busy, m_inflight);
      chk("resp_valid", resp_valid, e_rv);
      chk("resp_data", resp_data, (e_rv != 0) ? alu_f(m_a, m_b, m_c) : 32'd0);
      if (m_inflight && m_age == 0) begin
        chk("alu_v1", alu_val1, m_a);
        chk("alu_v2", alu_val2, m_b);
        chk("alu_cmd", alu_EXE_CMD, m_c);
      end else begin
        chk("alu_v1 idle", alu_val1, 0);
        chk("alu_v2 idle", alu_val2, 0);
        chk("alu_cmd idle", alu_EXE_CMD, 4'd15);
      end
      // Advance to the next cycle.
      if (m_inflight) begin
        if (m_age >= 1 && resp_ready[m_own]) m_inflight = 1'b0;
        else m_age++;
      end else if ((req_valid & e_rdy) != 2'b00) begin
        m_own      = e_rdy[1];
        m_a        = m_own ? val1_b : val1_a;
        m_b        = m_own ? val2_b : val2_a;
        m_c        = m_own ? EXE_CMD_b : EXE_CMD_a;
        m_rr       = ~m_own;
        m_inflight = 1'b1;
        m_age      = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic wait_accept(input int p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req_valid[p] && req_ready[p]) ok = 1'b1;
    end
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (resp_valid != 2'b00) ok = 1'b1;
    end
  endtask

  task automatic do_single(input int p, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] c, input logic [31:0] exp, input string nm);
    bit ok;
    logic [1:0] m;
    m = 2'b01 << p;
    @(posedge clk); #1;
    if (p == 0) begin val1_a = a; val2_a = b; EXE_CMD_a = c; end
    else        begin val1_b = b; val1_b = a; val2_b = b; EXE_CMD_b = c; end
    req_valid = m; resp_ready = 2'b11;
    wait_accept(p, ok);
    chk({nm, " accepted"}, ok, 1);
    @(posedge clk); #1 req_valid = 2'b00;
    @(negedge clk);
    chk({nm, " exec cmd"}, alu_EXE_CMD, c);
    @(negedge clk);
    chk({nm, " resp_valid"}, resp_valid, m);
    chk({nm, " resp_data"}, resp_data, exp);
  endtask

  task automatic rand_payload(output logic [31:0] a, output logic [31:0] b,
                              output logic [3:0] c);
    logic [3:0] cmds [9];
    cmds = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
    a = $urandom;
    b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
    c = cmds[$urandom_range(0, 8)];
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int ops, cyc;
    logic [1:0] acc;
    logic [31:0] ra, rb;
    logic [3:0] rc;

    rst = 1'b0; req_valid = 2'b00; resp_ready = 2'b00;
    val1_a = 0; val2_a = 0; val1_b = 0; val2_b = 0; EXE_CMD_a = 0; EXE_CMD_b = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle cmd", alu_EXE_CMD, 4'd15);
      chk("idle v1", alu_val1, 0);
      chk("idle busy", busy, 0);
      chk("idle resp_valid", resp_valid, 2'b00);
    end

    // Single operations, literal results
    do_single(0, 32'd15, 32'd7, CMD_ADD, 32'd22, "A add");
    do_single(0, 32'h8000_0000, 32'd4, CMD_SAR, 32'hF800_0000, "A sar");
    do_single(1, 32'hF0F0_0000, 32'd8, CMD_SHR, 32'h00F0_F000, "B shr");
    do_single(1, 32'h0000_00FF, 32'h0000_0F0F, CMD_XOR, 32'h0000_0FF0, "B xor");
    @(posedge clk);

    // Both valid after reset: A first, then alternation
    do_reset();
    @(posedge clk); #1;
    val1_a = 15; val2_a = 7; EXE_CMD_a = CMD_SUB;
    val1_b = 15; val2_b = 7; EXE_CMD_b = CMD_AND;
    req_valid = 2'b11; resp_ready = 2'b11;
    @(negedge clk);
    chk("first grant A", req_ready, 2'b01);
    for (int i = 0; i < 4; i++) begin
      wait_resp(ok);
      chk("alt resp seen", ok, 1);
      chk("alt owner", resp_valid, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("alt data", resp_data, (i % 2 == 0) ? 32'd8 : 32'd7);
    end
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (4) @(posedge clk);

    // Backpressure on B while A waits
    do_reset();
    @(posedge clk); #1;
    val1_b = 3; val2_b = 4; EXE_CMD_b = CMD_ADD;
    req_valid = 2'b10; resp_ready = 2'b01;
    wait_accept(1, ok);
    chk("bp B accepted", ok, 1);
    @(posedge clk); #1;
    val1_a = 1; val2_a = 1; EXE_CMD_a = CMD_ADD; req_valid = 2'b11;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp resp_valid", resp_valid, 2'b10);
      chk("bp resp_data", resp_data, 32'd7);
      chk("bp req_ready", req_ready, 2'b00);
    end
    @(posedge clk); #1 resp_ready = 2'b11;
    @(negedge clk);
    chk("bp hs cycle ready", req_ready, 2'b00);
    @(negedge clk);
    chk("bp A after", req_ready, 2'b01);
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (4) @(posedge clk);

    // Reset during EXEC
    @(posedge clk); #1;
    val1_a = 9; val2_a = 9; EXE_CMD_a = CMD_ADD; req_valid = 2'b01; resp_ready = 2'b11;
    wait_accept(0, ok);
    chk("mid A accepted", ok, 1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("mid in exec", busy, 1);
    rst = 1'b0;
    #1;
    chk("mid busy drop", busy, 0);
    chk("mid resp_valid", resp_valid, 2'b00);
    chk("mid resp_data", resp_data, 0);
    chk("mid alu cmd", alu_EXE_CMD, 4'd15);
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mid no resp", resp_valid, 2'b00);
    end
    @(posedge clk); #1;
    val1_b = 2; val2_b = 2; EXE_CMD_b = CMD_OR; req_valid = 2'b11;
    @(negedge clk);
    chk("mid rr reset", req_ready, 2'b01);
    @(posedge clk); #1 req_valid = 2'b10;
    repeat (8) @(posedge clk);
    #1 req_valid = 2'b00;
    repeat (4) @(posedge clk);

    // Random traffic with valid/ready stalls
    ops = 0; cyc = 0; acc = 2'b00;
    while (ops < 1000 && cyc < 30000) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (!req_valid[p] || acc[p]) begin
          rand_payload(ra, rb, rc);
          if (p == 0) begin val1_a = ra; val2_a = rb; EXE_CMD_a = rc; end
          else        begin val1_b = ra; val2_b = rb; EXE_CMD_b = rc; end
          req_valid[p] = ($urandom_range(0, 3) != 0);
        end
      end
      resp_ready = 2'($urandom_range(0, 3));
      @(negedge clk);
      acc = req_valid & req_ready;
      ops += int'(acc[0]) + int'(acc[1]);
      cyc++;
    end
    chk("random ops reached", (ops >= 1000), 1);
    @(posedge clk); #1 req_valid = 2'b00; resp_ready = 2'b11;
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
